// File: rtl/pipeline_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundle of the signals that connect the pipeline stall/flush scheduler to the
// rest of the core.
//   Requests into the scheduler:
//     if_wait, mem_wait      - AXI fetch / data access still outstanding
//     stcl_lw, stcl_jmp      - load-use / branch-operand hazard stalls
//     div_busy               - multi-cycle divider occupying EXE
//     exc_req, eret_req      - exception / ERET committed by the MEM stage
//     exc_vector, epc        - redirect targets (32 bit)
//   Controls out of the scheduler:
//     stall[4:0], bubble[4:0] - per-register hold / NOP insert
//                               (bit0 PC, 1 IF/ID, 2 ID/EXE, 3 EXE/MEM, 4 MEM/WB)
//     flush                  - clear IF/ID, ID/EXE, EXE/MEM
//     new_pc_valid, new_pc   - one-cycle PC redirect strobe and target
//     stall_cnt              - saturating count of PC-stalled cycles
// The master modport is the pipeline side, the slave modport is the scheduler.
// ---------------------------------------------------------------------------
interface pipeline_ctrl_if;
  logic        if_wait;
  logic        mem_wait;
  logic        stcl_lw;
  logic        stcl_jmp;
  logic        div_busy;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] exc_vector;
  logic [31:0] epc;
  logic [4:0]  stall;
  logic [4:0]  bubble;
  logic        flush;
  logic        new_pc_valid;
  logic [31:0] new_pc;
  logic [31:0] stall_cnt;

  modport master (
    output if_wait, mem_wait, stcl_lw, stcl_jmp, div_busy,
           exc_req, eret_req, exc_vector, epc,
    input  stall, bubble, flush, new_pc_valid, new_pc, stall_cnt
  );

  modport slave (
    input  if_wait, mem_wait, stcl_lw, stcl_jmp, div_busy,
           exc_req, eret_req, exc_vector, epc,
    output stall, bubble, flush, new_pc_valid, new_pc, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush scheduler for the five-stage pipeline.
//   clk    - system clock, rising edge
//   rst_n  - synchronous active-low reset; also forces all controls low
//            combinationally while asserted
//   bus    - pipeline_ctrl_if.slave: stall requests and redirect requests in,
//            hold/bubble/flush controls, PC redirect and stall counter out
//
// In RUN the deepest stalled stage wins: everything upstream of it holds and
// the register just downstream of it takes a bubble. An exception/ERET is only
// accepted while the MEM-stage data access is idle. If an instruction fetch is
// still outstanding at that point, the redirect waits in DRAIN until the AXI
// read returns, so the fetch is never cancelled mid-flight; REDIRECT then
// emits the new PC and flushes the stale fetched word.
// ---------------------------------------------------------------------------
module pipeline_ctrl (
  input  logic            clk,
  input  logic            rst_n,
  pipeline_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  state_e      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  logic        accept_s;
  logic [4:0]  stall_s;
  logic [4:0]  bubble_s;
  logic        flush_s;
  logic        new_pc_valid_s;
  logic [31:0] new_pc_s;

  // A redirect can only be taken from RUN and never while a data access is
  // outstanding in MEM (the faulting/ERET instruction must be able to retire).
  assign accept_s = (state_q == ST_RUN) &&
                    (bus.exc_req || bus.eret_req) &&
                    !bus.mem_wait;

  // State register, latched redirect target and stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      target_q    <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state and target-latch logic.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      ST_RUN: begin
        if (accept_s) begin
          // exc_req outranks eret_req when both are raised together.
          if (bus.exc_req) begin
            target_d = bus.exc_vector;
          end else begin
            target_d = bus.epc;
          end
          if (bus.if_wait) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_REDIRECT;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Hold the redirect until the outstanding fetch has returned.
        if (!bus.if_wait) begin
          state_d = ST_REDIRECT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_REDIRECT: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Output decode: hold/bubble/flush plus the redirect strobe.
  always_comb begin
    stall_s        = 5'b00000;
    bubble_s       = 5'b00000;
    flush_s        = 1'b0;
    new_pc_valid_s = 1'b0;
    new_pc_s       = 32'd0;
    if (!rst_n) begin
      // Everything stays quiet while reset is asserted.
      stall_s        = 5'b00000;
      bubble_s       = 5'b00000;
      flush_s        = 1'b0;
      new_pc_valid_s = 1'b0;
      new_pc_s       = 32'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept_s) begin
            // The MEM instruction retires; everything younger is flushed.
            // The PC is only held if a fetch is still in flight.
            flush_s  = 1'b1;
            bubble_s = 5'b10000;
            stall_s  = {4'b0000, bus.if_wait};
          end else if (bus.mem_wait) begin
            stall_s  = 5'b01111;
            bubble_s = 5'b10000;
          end else if (bus.div_busy) begin
            stall_s  = 5'b00111;
            bubble_s = 5'b01000;
          end else if (bus.stcl_lw || bus.stcl_jmp) begin
            stall_s  = 5'b00011;
            bubble_s = 5'b00100;
          end else if (bus.if_wait) begin
            stall_s  = 5'b00001;
            bubble_s = 5'b00010;
          end else begin
            stall_s  = 5'b00000;
            bubble_s = 5'b00000;
          end
        end
        ST_DRAIN: begin
          stall_s = 5'b00001;
        end
        ST_REDIRECT: begin
          // Registered-state decode only; flush drops the stale fetched word.
          flush_s        = 1'b1;
          new_pc_valid_s = 1'b1;
          new_pc_s       = target_q;
        end
        default: begin
          stall_s  = 5'b00000;
          bubble_s = 5'b00000;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    if (stall_s[0] && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  assign bus.stall        = stall_s;
  assign bus.bubble       = bubble_s;
  assign bus.flush        = flush_s;
  assign bus.new_pc_valid = new_pc_valid_s;
  assign bus.new_pc       = new_pc_s;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_ctrl
// Directed bench for pipeline_ctrl. Inputs change just after the falling
// edge, outputs are sampled 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_pipeline_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pipeline_ctrl_if bus ();

  pipeline_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [4:0] st, input logic [4:0] bu,
                            input logic fl, input logic nv, input logic [31:0] npc);
    chk({tag, ".stall"},        {27'd0, bus.stall},        {27'd0, st});
    chk({tag, ".bubble"},       {27'd0, bus.bubble},       {27'd0, bu});
    chk({tag, ".flush"},        {31'd0, bus.flush},        {31'd0, fl});
    chk({tag, ".new_pc_valid"}, {31'd0, bus.new_pc_valid}, {31'd0, nv});
    chk({tag, ".new_pc"},       bus.new_pc,                npc);
  endtask

  task automatic drive(input logic ifw, input logic memw, input logic lw, input logic jmp,
                       input logic div, input logic exc, input logic eret);
    bus.if_wait  = ifw;
    bus.mem_wait = memw;
    bus.stcl_lw  = lw;
    bus.stcl_jmp = jmp;
    bus.div_busy = div;
    bus.exc_req  = exc;
    bus.eret_req = eret;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    bus.exc_vector = 32'd0;
    bus.epc        = 32'd0;
    // Requests asserted during reset must not leak to the outputs.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    expect_out("in_reset", 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd0);

    @(negedge clk); rst_n = 1'b1; drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    expect_out("after_reset", 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd0);
    chk("after_reset.stall_cnt", bus.stall_cnt, 32'd0);

    // Single-source stalls.
    @(negedge clk); drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    expect_out("lw", 5'b00011, 5'b00100, 1'b0, 1'b0, 32'd0);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    expect_out("idle1", 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd0);
    chk("lw.stall_cnt", bus.stall_cnt, 32'd1);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); #1;
    expect_out("jmp", 5'b00011, 5'b00100, 1'b0, 1'b0, 32'd0);
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    expect_out("ifw", 5'b00001, 5'b00010, 1'b0, 1'b0, 32'd0);
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); #1;
    expect_out("div", 5'b00111, 5'b01000, 1'b0, 1'b0, 32'd0);

    // Deepest request wins for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); #1;
      expect_out("mem", 5'b01111, 5'b10000, 1'b0, 1'b0, 32'd0);
    end
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("mem.stall_cnt", bus.stall_cnt, 32'd7);

    // Exception with no fetch outstanding: accept, then REDIRECT next cycle.
    @(negedge clk); bus.exc_vector = 32'hBFC0_0380;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
    expect_out("exc_accept", 5'b00000, 5'b10000, 1'b1, 1'b0, 32'd0);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    expect_out("exc_redirect", 5'b00000, 5'b00000, 1'b1, 1'b1, 32'hBFC0_0380);
    @(negedge clk); #1;
    expect_out("exc_run", 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd0);
    chk("exc.stall_cnt", bus.stall_cnt, 32'd7);

    // ERET with a fetch outstanding: DRAIN ignores other requests.
    @(negedge clk); bus.epc = 32'h8000_1000;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    expect_out("eret_accept", 5'b00001, 5'b10000, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0); #1;
      expect_out("drain", 5'b00001, 5'b00000, 1'b0, 1'b0, 32'd0);
    end
    @(negedge clk); drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    expect_out("drain_last", 5'b00001, 5'b00000, 1'b0, 1'b0, 32'd0);
    @(negedge clk); #1;
    expect_out("eret_redirect", 5'b00000, 5'b00000, 1'b1, 1'b1, 32'h8000_1000);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    expect_out("eret_run", 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd0);
    chk("eret.stall_cnt", bus.stall_cnt, 32'd13);

    // Request held through REDIRECT is re-accepted in the following RUN cycle.
    @(negedge clk); bus.exc_vector = 32'hA000_0000;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
    expect_out("b2b_accept1", 5'b00000, 5'b10000, 1'b1, 1'b0, 32'd0);
    @(negedge clk); #1;
    expect_out("b2b_redirect1", 5'b00000, 5'b00000, 1'b1, 1'b1, 32'hA000_0000);
    @(negedge clk); bus.exc_vector = 32'hA000_0100; #1;
    expect_out("b2b_accept2", 5'b00000, 5'b10000, 1'b1, 1'b0, 32'd0);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    expect_out("b2b_redirect2", 5'b00000, 5'b00000, 1'b1, 1'b1, 32'hA000_0100);

    // exc+eret blocked by mem_wait, then exc_vector chosen.
    @(negedge clk); bus.exc_vector = 32'hBFC0_0380; bus.epc = 32'h8000_1000;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
      expect_out("memblock", 5'b01111, 5'b10000, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); #1;
    expect_out("both_accept", 5'b00000, 5'b10000, 1'b1, 1'b0, 32'd0);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    expect_out("both_redirect", 5'b00000, 5'b00000, 1'b1, 1'b1, 32'hBFC0_0380);
    chk("both.stall_cnt", bus.stall_cnt, 32'd15);

    // Reset during DRAIN aborts the redirect.
    @(negedge clk); drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    expect_out("rst_accept", 5'b00001, 5'b10000, 1'b1, 1'b0, 32'd0);
    @(negedge clk); rst_n = 1'b0; drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    expect_out("rst_drain", 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd0);
    @(negedge clk); rst_n = 1'b1; drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    expect_out("rst_after1", 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd0);
    chk("rst.stall_cnt", bus.stall_cnt, 32'd0);
    @(negedge clk); #1;
    expect_out("rst_after2", 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd0);
    @(negedge clk); #1;
    expect_out("rst_after3", 5'b00000, 5'b00000, 1'b0, 1'b0, 32'd0);

    // Counter saturation.
    @(negedge clk); force dut.stall_cnt_q = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); release dut.stall_cnt_q; #1;
    chk("sat1.stall_cnt", bus.stall_cnt, 32'hFFFF_FFFF);
    @(negedge clk); #1;
    chk("sat2.stall_cnt", bus.stall_cnt, 32'hFFFF_FFFF);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("sat3.stall_cnt", bus.stall_cnt, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
